multicycle_left_shifter: RTL and testbench
==========================================

MULTICYCLE_LEFT_SHIFTER -- requirements
Module: multicycle_left_shifter

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 data_in  input  32  operand; captured with start.
REQ-006 shamt  input  5  left shift amount 0..31; captured with start.
REQ-007 rotate  input  1  1 = rotate left, 0 = logical shift left with zero fill; captured with start.
REQ-008 busy  output  1  high from the cycle after start is accepted until the block returns to IDLE.
REQ-009 done  output  1  single-cycle completion pulse.
REQ-010 data_out  output  32  result; holds its value until the next completion.

Function
REQ-011 The block SHALL use FSM states IDLE, SHIFT and DONE, and a 3-bit stage counter over 0..4.
REQ-012 In IDLE with start=1 at edge E0: working register <= data_in; shamt and rotate are latched; stage <= 0; state <= SHIFT; busy <= 1.
REQ-013 In SHIFT, at each edge, if latched shamt[stage]=1 the working register SHALL shift left by 2^stage (zero fill, or wrap MSBs into LSBs when rotate=1), otherwise it holds; stage then increments.
REQ-014 Stages 0..4 SHALL execute at edges E1..E5; at E5 data_out <= final result, done <= 1, state <= DONE.
REQ-015 At E6, DONE -> IDLE, done <= 0, busy <= 0; done is high for exactly one cycle.
REQ-016 Latency SHALL be fixed: done is high in the 5th cycle after start is sampled, independent of shamt (shamt=0 included).
REQ-017 start SHALL be ignored in SHIFT and DONE; latched operands SHALL NOT change mid-operation; a start sampled in the same cycle that busy falls is not accepted, and a new start is accepted from the first IDLE cycle.
REQ-018 Back-to-back operations SHALL be possible with one IDLE cycle between the done pulse and the next accept.
REQ-019 shamt=31 with rotate=0 SHALL leave only data_in[0], placed in bit 31; rotate=1 SHALL never lose bits (popcount preserved).
REQ-020 data_out SHALL change only at the completion edge or on reset.

Reset
REQ-021 When reset_n is low, state SHALL be IDLE, stage=0, busy=0, done=0, data_out=32'h00000000, and the working and latched registers SHALL be 0.
REQ-022 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first operation after release SHALL complete normally.

Verification
REQ-023 data_in=32'h00000001, shamt=31, rotate=0, start one cycle -> done high in the 5th cycle after start is sampled, data_out=32'h80000000, busy low the next cycle.
REQ-024 data_in=32'h80000001, shamt=1 -> rotate=1 gives 32'h00000003; rotate=0 gives 32'h00000002.
REQ-025 data_in=32'h12345678, shamt=16, rotate=1 -> data_out=32'h56781234; shamt=0 on 32'hDEADBEEF -> 32'hDEADBEEF with the same 5-cycle latency.
REQ-026 start held high for 10 cycles while data_in changes to 32'hFFFFFFFF after accept -> exactly one done pulse per accepted start, and the first result reflects the originally captured operand.
REQ-027 reset_n pulled low during stage 2 -> busy=0, done=0, data_out=32'h00000000 immediately (asynchronously); no done follows; the next operation (32'h0000000F, shamt=4, rotate=0) -> 32'h000000F0.
REQ-028 Randomized self-check: at least 1000 random data_in/shamt/rotate operations compared against a reference model (data_in << shamt, or the rotate-left equivalent) -> zero mismatches, constant latency.

Source files
------------

// File: rtl/multicycle_left_shifter.sv
// Multicycle 32-bit left shifter / rotator: five log-stage passes (1,2,4,8,16 bits),
// one per clock, giving a fixed latency independent of the shift amount.
module multicycle_left_shifter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] data_in,
    input  logic [4:0]  shamt,
    input  logic        rotate,
    output logic        busy,
    output logic        done,
    output logic [31:0] data_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [2:0]  stage_r;
    logic [31:0] work_r;
    logic [4:0]  shamt_r;
    logic        rotate_r;
    logic        busy_s;
    logic        done_s;
    logic        busy_r;
    logic        done_r;
    logic [31:0] data_out_r;
    logic [31:0] shifted_s;

    // One log-shifter stage: moves the word by 2^stage when enabled, wrapping if rotating.
    function automatic logic [31:0] shift_stage(input logic [31:0] word,
                                                input logic [2:0]  stage,
                                                input logic        enable,
                                                input logic        rot);
        logic [5:0]  amount;
        logic [31:0] result;
        amount = 6'd1 << stage;
        if (!enable) begin
            result = word;
        end else if (rot) begin
            result = (word << amount) | (word >> (6'd32 - amount));
        end else begin
            result = word << amount;
        end
        return result;
    endfunction

    assign shifted_s = shift_stage(work_r, stage_r, shamt_r[stage_r], rotate_r);

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:    state_next_s = start ? SHIFT : IDLE;
            SHIFT:   state_next_s = (stage_r == 3'd4) ? DONE : SHIFT;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Next values of the registered status outputs.
    always_comb begin
        busy_s = (state_next_s != IDLE);
        done_s = (state_r == SHIFT) && (stage_r == 3'd4);
    end

    // Status output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= busy_s;
            done_r <= done_s;
        end
    end

    // Operand capture, stage walk and result latch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            work_r     <= 32'h0000_0000;
            shamt_r    <= 5'd0;
            rotate_r   <= 1'b0;
            stage_r    <= 3'd0;
            data_out_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        work_r   <= data_in;
                        shamt_r  <= shamt;
                        rotate_r <= rotate;
                        stage_r  <= 3'd0;
                    end
                end
                SHIFT: begin
                    work_r <= shifted_s;
                    if (stage_r == 3'd4) begin
                        data_out_r <= shifted_s;
                        stage_r    <= 3'd0;
                    end else begin
                        stage_r <= stage_r + 3'd1;
                    end
                end
                DONE: begin
                    stage_r <= 3'd0;
                end
                default: begin
                    stage_r <= 3'd0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign data_out = data_out_r;

endmodule

// File: tb/tb_multicycle_left_shifter.sv
// Self-checking bench for multicycle_left_shifter: directed cases, held start,
// mid-operation reset and a randomized run against a reference model via a scoreboard.
module tb_multicycle_left_shifter;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic        rotate;
    logic        busy;
    logic        done;
    logic [31:0] data_out;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    multicycle_left_shifter dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .data_in (data_in),
        .shamt   (shamt),
        .rotate  (rotate),
        .busy    (busy),
        .done    (done),
        .data_out(data_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] ref_model(input logic [31:0] d, input logic [4:0] s, input logic r);
        logic [63:0] t;
        logic [31:0] res;
        if (r) begin
            t   = {d, d} << s;
            res = t[63:32];
        end else begin
            res = d << s;
        end
        return res;
    endfunction

    // One operation from IDLE: accept, latency, result, post-done idle and output hold.
    task automatic run_op(input logic [31:0] d, input logic [4:0] s, input logic r, output logic [31:0] got);
        int lat;
        bit seen;
        logic [31:0] exp;
        got = 32'h0;
        @(negedge clock);
        start = 1'b1; data_in = d; shamt = s; rotate = r;
        @(posedge clock); #1;
        start = 1'b0;
        exp_q.push_back(ref_model(d, s, r));
        data_in = $urandom; shamt = 5'($urandom); rotate = 1'($urandom);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL accept_busy: got %b want 1", busy); end
        lat = 0; seen = 0;
        while (!seen && lat < 10) begin
            @(posedge clock); #1;
            lat++;
            if (done === 1'b1) seen = 1;
        end
        checks++;
        if (!seen || lat != 5) begin
            errors++; $display("FAIL latency: seen=%0d got %0d cycles want 5", seen, lat);
        end
        if (seen) begin
            exp = exp_q.pop_front();
            got = data_out;
            checks++;
            if (data_out !== exp) begin
                errors++; $display("FAIL result d=%h s=%0d r=%0d: got %h want %h", d, s, r, data_out, exp);
            end
            @(posedge clock); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || data_out !== exp) begin
                errors++; $display("FAIL after_done: busy=%b done=%b out=%h want 0 0 %h", busy, done, data_out, exp);
            end
        end else begin
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; data_in = 32'hA5A5_A5A5; shamt = 5'd3; rotate = 1'b1;
        #12;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data_out !== 32'h0) begin
            errors++; $display("FAIL reset_state: busy=%b done=%b out=%h want 0 0 00000000", busy, done, data_out);
        end
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] got;
        run_op(32'h0000_0001, 5'd31, 1'b0, got);
        run_op(32'hFFFF_FFFF, 5'd31, 1'b0, got);
        run_op(32'h8000_0001, 5'd1,  1'b1, got);
        run_op(32'h8000_0001, 5'd1,  1'b0, got);
        run_op(32'h1234_5678, 5'd16, 1'b1, got);
        run_op(32'hDEAD_BEEF, 5'd0,  1'b0, got);
        run_op(32'hDEAD_BEEF, 5'd31, 1'b1, got);
        checks++;
        if (got !== 32'hEF56_DF77) begin
            errors++; $display("FAIL rotate31: got %h want ef56df77", got);
        end
    endtask

    // start held for 10 cycles: accepts at cycle 0 and again at cycle 7 (first IDLE after DONE).
    task automatic test_latched_operands();
        int ndone;
        logic [31:0] exp;
        ndone = 0;
        @(negedge clock);
        start = 1'b1; data_in = 32'h1234_5678; shamt = 5'd4; rotate = 1'b0;
        exp_q.push_back(32'h2345_6780);
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(posedge clock); #1;
            if (cyc == 0) begin
                data_in = 32'hFFFF_FFFF;
                exp_q.push_back(32'hFFFF_FFF0);
            end
            if (cyc == 9) start = 1'b0;
            if (done === 1'b1) begin
                checks++;
                if (!((ndone == 0 && cyc == 5) || (ndone == 1 && cyc == 12))) begin
                    errors++; $display("FAIL held_done_timing: pulse %0d at cycle %0d want 5/12", ndone, cyc);
                end
                ndone++;
                if (exp_q.size() > 0) begin
                    exp = exp_q.pop_front();
                    checks++;
                    if (data_out !== exp) begin
                        errors++; $display("FAIL held_result: got %h want %h", data_out, exp);
                    end
                end
            end
        end
        checks++;
        if (ndone != 2) begin errors++; $display("FAIL held_pulses: got %0d want 2", ndone); end
        exp_q.delete();
    endtask

    task automatic test_reset_abort();
        logic [31:0] got;
        int ndone;
        ndone = 0;
        @(negedge clock);
        start = 1'b1; data_in = 32'hFFFF_0000; shamt = 5'd7; rotate = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(posedge clock);
        @(posedge clock); #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || data_out !== 32'h0) begin
            errors++; $display("FAIL async_abort: busy=%b done=%b out=%h want 0 0 00000000", busy, done, data_out);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clock); #1;
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
        run_op(32'h0000_000F, 5'd4, 1'b0, got);
    endtask

    task automatic test_random();
        logic [31:0] got;
        logic [31:0] d;
        logic [4:0]  s;
        for (int i = 0; i < 1000; i++) begin
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            run_op(d, s, 1'b1, got);
            checks++;
            if ($countones(got) != $countones(d)) begin
                errors++; $display("FAIL popcount d=%h s=%0d: got %0d want %0d", d, s, $countones(got), $countones(d));
            end
            d = $urandom;
            s = 5'($urandom_range(0, 31));
            run_op(d, s, 1'b0, got);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_latched_operands();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
